program_sequencer: RTL and testbench

- Fetch/sequencing controller for the Jac1-8 core; owns the program counter that addresses program memory.
- Reads the combinational instruction word at the current PC and resolves control flow (goto, ifz, ifnz, nop) itself.
- Issues all other instructions to the datapath over a valid/done handshake.
- Provides start/halt run control, a retired-instruction counter and a sticky out-of-range fault.

---
 rtl/program_sequencer.sv | 167 ++++++++++++++++
 tb/tb_program_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer for the Jac1-8 core.
// Owns the program counter, resolves goto/ifz/ifnz/nop locally and hands every
// other instruction to the datapath over a valid/done handshake. Provides
// start/halt run control, a retired-instruction counter and a sticky
// out-of-range fault.
module program_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int IR_WIDTH  = 16,
  parameter int CMD_CNT   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic [IR_WIDTH-1:0]  ir,
  input  logic                 zero,
  input  logic                 exec_done,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 exec_valid,
  output logic [IR_WIDTH-1:0]  exec_ir,
  output logic                 busy,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [4:0] OP_GOTO = 5'b10000;
  localparam logic [4:0] OP_IFZ  = 5'b10001;
  localparam logic [4:0] OP_IFNZ = 5'b10010;

  localparam logic [31:0] CMD_LIMIT = 32'(CMD_CNT);

  logic [1:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 exec_valid_q, exec_valid_d;
  logic [IR_WIDTH-1:0]  exec_ir_q, exec_ir_d;
  logic                 fault_q, fault_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic [4:0]           op;
  logic [PC_WIDTH-1:0]  param;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic [PC_WIDTH-1:0]  pc_skip;

  // Retirement bookkeeping shared by every instruction that moves the pc.
  logic                 retire;
  logic [PC_WIDTH-1:0]  next_pc;
  logic [1:0]           resume_state;

  assign op      = ir[15:11];
  assign param   = PC_WIDTH'(ir[7:0]);
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign pc_skip = pc_inc + param;

  // Next-state, pc and handshake logic; a retiring instruction whose target
  // leaves program memory diverts to FAULT but still loads the pc and counts.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    exec_valid_d = exec_valid_q;
    exec_ir_d    = exec_ir_q;
    fault_d      = fault_q;
    retired_d    = retired_q;
    retire       = 1'b0;
    next_pc      = pc_q;
    resume_state = state_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !halt) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (ir == '0) begin
          retire       = 1'b1;
          next_pc      = pc_inc;
          resume_state = ST_FETCH;
        end else if (op == OP_GOTO) begin
          retire       = 1'b1;
          next_pc      = param;
          resume_state = ST_FETCH;
        end else if (op == OP_IFZ) begin
          retire       = 1'b1;
          next_pc      = zero ? pc_skip : pc_inc;
          resume_state = ST_FETCH;
        end else if (op == OP_IFNZ) begin
          retire       = 1'b1;
          next_pc      = zero ? pc_inc : pc_skip;
          resume_state = ST_FETCH;
        end else begin
          exec_ir_d    = ir;
          exec_valid_d = 1'b1;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (exec_done) begin
          exec_valid_d = 1'b0;
          retire       = 1'b1;
          next_pc      = pc_inc;
          resume_state = halt ? ST_IDLE : ST_FETCH;
        end
      end

      ST_FAULT: begin
        exec_valid_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          fault_d = 1'b0;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (retire) begin
      pc_d      = next_pc;
      retired_d = retired_q + CNT_WIDTH'(1);
      if (32'(next_pc) >= CMD_LIMIT) begin
        fault_d = 1'b1;
        state_d = ST_FAULT;
      end else begin
        state_d = resume_state;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      exec_valid_q <= 1'b0;
      exec_ir_q    <= '0;
      fault_q      <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      exec_valid_q <= exec_valid_d;
      exec_ir_q    <= exec_ir_d;
      fault_q      <= fault_d;
      retired_q    <= retired_d;
    end
  end

  assign pc         = pc_q;
  assign exec_valid = exec_valid_q;
  assign exec_ir    = exec_ir_q;
  assign fault      = fault_q;
  assign retired    = retired_q;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_ISSUE);

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: directed program sequences with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        res_n = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        zero = 1'b0;
  logic        exec_done = 1'b0;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        exec_valid;
  logic [15:0] exec_ir;
  logic        busy;
  logic        fault;
  logic [15:0] retired;

  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  program_sequencer #(
    .PC_WIDTH (8),
    .IR_WIDTH (16),
    .CMD_CNT  (64),
    .CNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .start     (start),
    .halt      (halt),
    .ir        (ir),
    .zero      (zero),
    .exec_done (exec_done),
    .pc        (pc),
    .exec_valid(exec_valid),
    .exec_ir   (exec_ir),
    .busy      (busy),
    .fault     (fault),
    .retired   (retired)
  );

  // Program memory answers combinationally at the current pc.
  assign ir = mem[pc];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural model: the program as seen from outside, not the RTL's states.
  typedef enum {M_IDLE, M_RUN, M_WAIT, M_FAULTED} mode_t;
  mode_t       m_mode    = M_IDLE;
  int          m_pc      = 0;
  int          m_retired = 0;
  bit          m_fault   = 1'b0;
  bit          m_valid   = 1'b0;
  int          m_exec_ir = 0;

  task automatic model_retire(input int target, input mode_t then_mode);
    m_pc      = target % 256;
    m_retired = (m_retired + 1) % 65536;
    if (m_pc >= 64) begin
      m_fault = 1'b1;
      m_mode  = M_FAULTED;
    end else begin
      m_mode = then_mode;
    end
  endtask

  // Model advances on each rising edge and clears at once on reset.
  always @(posedge clk or negedge res_n) begin
    int instr;
    int op;
    int prm;
    if (!res_n) begin
      m_mode = M_IDLE; m_pc = 0; m_retired = 0;
      m_fault = 1'b0; m_valid = 1'b0; m_exec_ir = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start && !halt) m_mode = M_RUN;
        M_RUN: begin
          if (halt) begin
            m_mode = M_IDLE;
          end else begin
            instr = int'(mem[m_pc]);
            op    = instr >> 11;
            prm   = instr & 255;
            if (instr == 0)       model_retire(m_pc + 1, M_RUN);
            else if (op == 16)    model_retire(prm, M_RUN);
            else if (op == 17)    model_retire(zero ? m_pc + 1 + prm : m_pc + 1, M_RUN);
            else if (op == 18)    model_retire(zero ? m_pc + 1 : m_pc + 1 + prm, M_RUN);
            else begin
              m_exec_ir = instr;
              m_valid   = 1'b1;
              m_mode    = M_WAIT;
            end
          end
        end
        M_WAIT: begin
          if (exec_done) begin
            m_valid = 1'b0;
            model_retire(m_pc + 1, halt ? M_IDLE : M_RUN);
          end
        end
        M_FAULTED: begin
          if (start) begin
            m_pc = 0; m_fault = 1'b0; m_mode = M_RUN;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    check_output("model_pc",         32'(pc),         32'(m_pc));
    check_output("model_exec_valid", 32'(exec_valid), 32'(m_valid));
    check_output("model_exec_ir",    32'(exec_ir),    32'(m_exec_ir));
    check_output("model_busy",       32'(busy),       32'(m_mode == M_RUN || m_mode == M_WAIT));
    check_output("model_fault",      32'(fault),      32'(m_fault));
    check_output("model_retired",    32'(retired),    32'(m_retired));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic h, input logic z, input logic d);
    start = s; halt = h; zero = z; exec_done = d;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h8008;  // goto 8
    mem[8]  = 16'h800A;  // goto 10
    mem[10] = 16'h8802;  // ifz 2
    mem[11] = 16'h8014;  // goto 20
    mem[20] = 16'h8801;  // ifz 1
    mem[22] = 16'h800F;  // goto 15
    mem[15] = 16'h9003;  // ifnz 3
    mem[19] = 16'h8000;  // goto 0

    #1 res_n = 1'b0;
    tick(); tick();
    check_output("reset_pc",      32'(pc),         32'h0);
    check_output("reset_valid",   32'(exec_valid), 32'h0);
    check_output("reset_busy",    32'(busy),       32'h0);
    check_output("reset_retired", 32'(retired),    32'h0);
    res_n = 1'b1;
    tick();

    // goto 8 from pc 0
    apply_stimulus(1, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0);
    check_output("start_busy", 32'(busy), 32'h1);
    tick();
    check_output("goto_pc",      32'(pc),         32'd8);
    check_output("goto_retired", 32'(retired),    32'd1);
    check_output("goto_valid",   32'(exec_valid), 32'h0);
    apply_stimulus(0, 1, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0);
    check_output("halt_fetch_busy", 32'(busy), 32'h0);
    check_output("halt_fetch_pc",   32'(pc),   32'd8);

    // Conditional skips
    apply_stimulus(1, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0); tick();
    check_output("goto10_pc", 32'(pc), 32'd10);
    tick();
    check_output("ifz_nz_pc", 32'(pc), 32'd11);
    tick();
    check_output("goto20_pc", 32'(pc), 32'd20);
    apply_stimulus(0, 0, 1, 0); tick();
    check_output("ifz_z_pc", 32'(pc), 32'd22);
    apply_stimulus(0, 0, 0, 0); tick();
    check_output("goto15_pc", 32'(pc), 32'd15);
    tick();
    check_output("ifnz_nz_pc",   32'(pc),      32'd19);
    check_output("ifnz_retired", 32'(retired), 32'd7);
    apply_stimulus(0, 1, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0);

    // Datapath instruction with a 4-cycle handshake
    mem[0] = 16'h4903;
    mem[1] = 16'h1234;
    mem[2] = 16'h800A;   // goto 10
    apply_stimulus(1, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0); tick();
    check_output("goto0_pc", 32'(pc), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_output("issue_valid", 32'(exec_valid), 32'h1);
      check_output("issue_ir",    32'(exec_ir),    32'h4903);
      check_output("issue_pc",    32'(pc),         32'd0);
      apply_stimulus(0, 0, 0, (i == 3));
      tick();
    end
    apply_stimulus(0, 0, 0, 0);
    check_output("done_valid",   32'(exec_valid), 32'h0);
    check_output("done_pc",      32'(pc),         32'd1);
    check_output("done_retired", 32'(retired),    32'd9);

    // Halt raised mid-handshake
    tick();
    check_output("issue2_ir", 32'(exec_ir), 32'h1234);
    apply_stimulus(0, 1, 0, 0); tick();
    check_output("halt_issue_valid", 32'(exec_valid), 32'h1);
    check_output("halt_issue_busy",  32'(busy),       32'h1);
    apply_stimulus(0, 1, 0, 1); tick();
    apply_stimulus(0, 0, 0, 0);
    check_output("halt_done_busy",  32'(busy),       32'h0);
    check_output("halt_done_pc",    32'(pc),         32'd2);
    check_output("halt_done_valid", 32'(exec_valid), 32'h0);
    tick();
    check_output("idle_hold_pc", 32'(pc), 32'd2);

    // Resume, then fault on an out-of-range skip
    mem[10] = 16'h88F0;  // ifz 0xF0
    apply_stimulus(1, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0);
    check_output("resume_pc",   32'(pc),   32'd2);
    check_output("resume_busy", 32'(busy), 32'h1);
    tick();
    check_output("resume_goto_pc", 32'(pc), 32'd10);
    apply_stimulus(0, 0, 1, 0); tick();
    check_output("fault_flag",    32'(fault),   32'h1);
    check_output("fault_pc",      32'(pc),      32'd251);
    check_output("fault_busy",    32'(busy),    32'h0);
    check_output("fault_retired", 32'(retired), 32'd12);
    apply_stimulus(0, 1, 0, 0); tick();
    check_output("fault_halt_ignored", 32'(fault), 32'h1);
    apply_stimulus(1, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0);
    check_output("clear_fault", 32'(fault), 32'h0);
    check_output("clear_pc",    32'(pc),    32'd0);
    check_output("clear_busy",  32'(busy),  32'h1);

    // Asynchronous reset in the middle of a handshake
    tick();
    check_output("pre_reset_valid", 32'(exec_valid), 32'h1);
    tick();
    #2 res_n = 1'b0;
    #1;
    check_output("async_valid",   32'(exec_valid), 32'h0);
    check_output("async_pc",      32'(pc),         32'h0);
    check_output("async_retired", 32'(retired),    32'h0);
    check_output("async_fault",   32'(fault),      32'h0);
    check_output("async_ir",      32'(exec_ir),    32'h0);
    tick();
    res_n = 1'b1;

    // start and halt together keep the block idle; stray exec_done ignored
    apply_stimulus(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("start_halt_busy", 32'(busy), 32'h0);
      check_output("start_halt_pc",   32'(pc),   32'h0);
    end
    apply_stimulus(0, 0, 0, 1); tick();
    apply_stimulus(0, 0, 0, 0);
    check_output("stray_done_retired", 32'(retired),    32'h0);
    check_output("stray_done_valid",   32'(exec_valid), 32'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
